// File: rtl/axi2mem_wr_burst_ctrl.sv
// Write-burst controller for the axi2mem bridge: takes one buffered AW burst,
// issues one memory write per W beat with FIXED/INCR/WRAP addressing, then returns B.
module axi2mem_wr_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      aw_valid_i,
    input  logic [ADDR_WIDTH-1:0]     aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic [ID_WIDTH-1:0]       aw_id_i,
    input  logic [USER_WIDTH-1:0]     aw_user_i,
    output logic                      aw_ready_o,
    input  logic                      w_valid_i,
    input  logic [DATA_WIDTH-1:0]     w_data_i,
    input  logic [DATA_WIDTH/8-1:0]   w_strb_i,
    input  logic                      w_last_i,
    output logic                      w_ready_o,
    output logic                      mem_req_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    output logic                      b_valid_o,
    output logic [1:0]                b_resp_o,
    output logic [ID_WIDTH-1:0]       b_id_o,
    output logic [USER_WIDTH-1:0]     b_user_o,
    input  logic                      b_ready_i
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_RESP} state_t;
    typedef enum logic [1:0] {B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10, B_RSVD = 2'b11} burst_t;

    state_t                  r_state;
    burst_t                  r_burst;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_wrap_mask;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [7:0]              r_cnt;
    logic                    r_err;
    logic                    r_aw_ready;
    logic                    r_b_valid;
    logic [1:0]              r_b_resp;
    logic [ID_WIDTH-1:0]     r_b_id;
    logic [USER_WIDTH-1:0]   r_b_user;

    logic                    w_in_burst;
    logic                    w_beat;
    logic                    w_last_beat;
    logic                    w_beat_err;
    logic                    w_wrap_len_ok;
    logic                    w_aw_err;
    burst_t                  w_aw_burst;
    logic [ADDR_WIDTH-1:0]   w_aw_mask;
    logic [ADDR_WIDTH-1:0]   w_incr_addr;
    logic [ADDR_WIDTH-1:0]   w_next_addr;

    assign w_in_burst  = (r_state == S_BURST);
    assign w_beat      = w_in_burst & w_valid_i & mem_gnt_i;
    assign w_last_beat = (r_cnt == r_len);
    assign w_beat_err  = (w_last_i != w_last_beat);

    assign w_wrap_len_ok = (aw_len_i == 8'd1) | (aw_len_i == 8'd3) |
                           (aw_len_i == 8'd7) | (aw_len_i == 8'd15);
    assign w_aw_err = (aw_burst_i == B_RSVD) | (aw_size_i > MAX_SIZE) |
                      ((aw_burst_i == B_WRAP) & ~w_wrap_len_ok);
    // Reserved bursts and illegal wrap lengths fall back to INCR addressing.
    assign w_aw_burst = ((aw_burst_i == B_RSVD) | ((aw_burst_i == B_WRAP) & ~w_wrap_len_ok))
                        ? B_INCR : burst_t'(aw_burst_i);
    assign w_aw_mask  = ((ADDR_WIDTH'(aw_len_i) + ADDR_WIDTH'(1)) << aw_size_i) - ADDR_WIDTH'(1);

    assign w_incr_addr = r_addr + (ADDR_WIDTH'(1) << r_size);

    always_comb begin
        w_next_addr = w_incr_addr;
        case (r_burst)
            B_FIXED: w_next_addr = r_addr;
            B_WRAP:  w_next_addr = (r_addr & ~r_wrap_mask) | (w_incr_addr & r_wrap_mask);
            default: w_next_addr = w_incr_addr;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_burst     <= B_FIXED;
            r_addr      <= '0;
            r_wrap_mask <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_aw_ready  <= 1'b1;
            r_b_valid   <= 1'b0;
            r_b_resp    <= '0;
            r_b_id      <= '0;
            r_b_user    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (aw_valid_i && r_aw_ready) begin
                        r_addr      <= aw_addr_i;
                        r_len       <= aw_len_i;
                        r_size      <= aw_size_i;
                        r_burst     <= w_aw_burst;
                        r_wrap_mask <= w_aw_mask;
                        r_b_id      <= aw_id_i;
                        r_b_user    <= aw_user_i;
                        r_cnt       <= '0;
                        r_err       <= w_aw_err;
                        r_aw_ready  <= 1'b0;
                        r_state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat) begin
                        r_addr <= w_next_addr;
                        r_cnt  <= r_cnt + 8'd1;
                        r_err  <= r_err | w_beat_err;
                        if (w_last_beat) begin
                            r_b_valid <= 1'b1;
                            r_b_resp  <= (r_err | w_beat_err) ? 2'b10 : 2'b00;
                            r_state   <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (b_ready_i) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign aw_ready_o  = r_aw_ready;
    assign mem_req_o   = w_in_burst & w_valid_i;
    assign mem_we_o    = w_in_burst & w_valid_i;
    assign w_ready_o   = w_beat;
    assign mem_addr_o  = r_addr;
    assign mem_be_o    = w_strb_i;
    assign mem_wdata_o = w_data_i;
    assign b_valid_o   = r_b_valid;
    assign b_resp_o    = r_b_resp;
    assign b_id_o      = r_b_id;
    assign b_user_o    = r_b_user;

endmodule

// File: tb/tb_axi2mem_wr_burst_ctrl.sv
// Directed scoreboard bench for axi2mem_wr_burst_ctrl: beat addresses and B responses
// are predicted at AW time and compared as the DUT issues them.
module tb_axi2mem_wr_burst_ctrl;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int UW = 6;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          aw_valid_i;
    logic [AW-1:0] aw_addr_i;
    logic [7:0]    aw_len_i;
    logic [2:0]    aw_size_i;
    logic [1:0]    aw_burst_i;
    logic [IW-1:0] aw_id_i;
    logic [UW-1:0] aw_user_i;
    logic          aw_ready_o;
    logic          w_valid_i;
    logic [DW-1:0] w_data_i;
    logic [SW-1:0] w_strb_i;
    logic          w_last_i;
    logic          w_ready_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [SW-1:0] mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          b_valid_o;
    logic [1:0]    b_resp_o;
    logic [IW-1:0] b_id_o;
    logic [UW-1:0] b_user_o;
    logic          b_ready_i;

    always #5 clk = ~clk;

    axi2mem_wr_burst_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .USER_WIDTH(UW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .aw_valid_i (aw_valid_i),
        .aw_addr_i  (aw_addr_i),
        .aw_len_i   (aw_len_i),
        .aw_size_i  (aw_size_i),
        .aw_burst_i (aw_burst_i),
        .aw_id_i    (aw_id_i),
        .aw_user_i  (aw_user_i),
        .aw_ready_o (aw_ready_o),
        .w_valid_i  (w_valid_i),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_last_i   (w_last_i),
        .w_ready_o  (w_ready_o),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_we_o   (mem_we_o),
        .mem_be_o   (mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i  (mem_gnt_i),
        .b_valid_o  (b_valid_o),
        .b_resp_o   (b_resp_o),
        .b_id_o     (b_id_o),
        .b_user_o   (b_user_o),
        .b_ready_i  (b_ready_i)
    );

    typedef struct {
        logic [1:0]    resp;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
    } b_exp_t;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [AW-1:0] exp_addr_q[$];
    b_exp_t        exp_b_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent address model: wrap region via modulo arithmetic rather than masks.
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] start, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst,
                                                 input int unsigned i);
        logic [AW-1:0] bytes, total, base;
        logic [1:0]    mode;
        bytes = AW'(1) << size;
        mode  = burst;
        if (burst == 2'b11) mode = 2'b01;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) mode = 2'b01;
        case (mode)
            2'b00:   return start;
            2'b10: begin
                total = (AW'(len) + 1) * bytes;
                base  = start - (start % total);
                return base + ((start - base) + AW'(i) * bytes) % total;
            end
            default: return start + AW'(i) * bytes;
        endcase
    endfunction

    task automatic start_burst(input logic [AW-1:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [IW-1:0] id, input logic [UW-1:0] user,
                               input int last_at);
        b_exp_t e;
        logic   err, ok;
        err = (burst == 2'b11) || (size > 3'd3) || (last_at != int'(len)) ||
              (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int unsigned i = 0; i <= len; i++) exp_addr_q.push_back(model_addr(addr, len, size, burst, i));
        e.resp = err ? 2'b10 : 2'b00;
        e.id   = id;
        e.user = user;
        exp_b_q.push_back(e);
        aw_addr_i = addr; aw_len_i = len; aw_size_i = size; aw_burst_i = burst;
        aw_id_i = id; aw_user_i = user; aw_valid_i = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = aw_ready_o;
            check("b_valid_idle", b_valid_o, 1'b0);
            @(posedge clk); #1;
        end
        aw_valid_i = 1'b0;
        check("aw_accept", ok, 1'b1);
    endtask

    task automatic beats(input int n, input int last_at, input logic toggle, output int cyc);
        int            k;
        logic [AW-1:0] a;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 64) begin
            w_valid_i = 1'b1;
            w_data_i  = {$urandom, $urandom};
            w_strb_i  = SW'($urandom);
            w_last_i  = (k == last_at);
            mem_gnt_i = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            check("mem_req", mem_req_o, 1'b1);
            check("mem_we", mem_we_o, 1'b1);
            if (mem_gnt_i) begin
                a = exp_addr_q.pop_front();
                check("w_ready", w_ready_o, 1'b1);
                check("mem_addr", mem_addr_o, a);
                check("mem_wdata", mem_wdata_o, w_data_i);
                check("mem_be", mem_be_o, w_strb_i);
                k++;
            end else begin
                check("w_ready_nogrant", w_ready_o, 1'b0);
                check("mem_addr_hold", mem_addr_o, exp_addr_q[0]);
            end
            @(posedge clk); #1;
            cyc++;
        end
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        mem_gnt_i = 1'b1;
        check("beats_done", k, n);
    endtask

    task automatic finish_b(input int hold);
        b_exp_t e;
        e = exp_b_q.pop_front();
        b_ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_valid_hold", b_valid_o, 1'b1);
            check("b_resp_hold", b_resp_o, e.resp);
            check("aw_ready_in_resp", aw_ready_o, 1'b0);
            check("w_ready_in_resp", w_ready_o, 1'b0);
            @(posedge clk); #1;
        end
        b_ready_i = 1'b1;
        @(negedge clk);
        check("b_valid", b_valid_o, 1'b1);
        check("b_resp", b_resp_o, e.resp);
        check("b_id", b_id_o, e.id);
        check("b_user", b_user_o, e.user);
        @(posedge clk); #1;
        b_ready_i = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_i = 1'b1; aw_valid_i = 1'b0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0;
        aw_burst_i = '0; aw_id_i = '0; aw_user_i = '0; w_valid_i = 1'b0; w_data_i = '0;
        w_strb_i = '0; w_last_i = 1'b0; mem_gnt_i = 1'b1; b_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("rst_aw_ready", aw_ready_o, 1'b1);
        check("rst_w_ready", w_ready_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_b_valid", b_valid_o, 1'b0);
        check("rst_b_resp", b_resp_o, 2'b00);
        check("rst_b_id", b_id_o, '0);
        check("rst_b_user", b_user_o, '0);
        @(posedge clk); #1;

        start_burst(32'h100, 8'd3, 3'd3, 2'b01, 4'd5, 6'h2A, 3);
        beats(4, 3, 1'b0, cyc);
        check("incr_cycles", cyc, 4);
        finish_b(0);

        start_burst(32'h118, 8'd3, 3'd3, 2'b10, 4'hA, 6'h11, 3);
        beats(4, 3, 1'b0, cyc);
        finish_b(0);

        start_burst(32'h44, 8'd2, 3'd2, 2'b00, 4'd7, 6'h05, 2);
        beats(3, 2, 1'b1, cyc);
        check("fixed_cycles", cyc, 5);
        finish_b(0);

        start_burst(32'h200, 8'd3, 3'd3, 2'b01, 4'd1, 6'h01, 2);
        beats(4, 2, 1'b0, cyc);
        finish_b(0);

        start_burst(32'h0, 8'd1, 3'd4, 2'b01, 4'd2, 6'h02, 1);
        beats(2, 1, 1'b0, cyc);
        finish_b(0);

        start_burst(32'h80, 8'd1, 3'd3, 2'b11, 4'd3, 6'h03, 1);
        beats(2, 1, 1'b0, cyc);
        finish_b(0);

        start_burst(32'h38, 8'd2, 3'd2, 2'b10, 4'd4, 6'h04, 2);
        beats(3, 2, 1'b0, cyc);
        finish_b(0);

        start_burst(32'h400, 8'd0, 3'd3, 2'b01, 4'd6, 6'h06, 0);
        beats(1, 0, 1'b0, cyc);
        aw_addr_i = 32'h508; aw_len_i = 8'd1; aw_size_i = 3'd3; aw_burst_i = 2'b10;
        aw_id_i = 4'd3; aw_user_i = 6'h33; aw_valid_i = 1'b1;
        finish_b(4);
        start_burst(32'h508, 8'd1, 3'd3, 2'b10, 4'd3, 6'h33, 1);
        beats(2, 1, 1'b0, cyc);
        finish_b(0);

        start_burst(32'h300, 8'd7, 3'd3, 2'b01, 4'd9, 6'h09, 7);
        beats(2, 7, 1'b0, cyc);
        w_valid_i = 1'b1; mem_gnt_i = 1'b1; rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", mem_req_o, 1'b0);
        check("midrst_b_valid", b_valid_o, 1'b0);
        check("midrst_aw_ready", aw_ready_o, 1'b1);
        check("midrst_w_ready", w_ready_o, 1'b0);
        @(posedge clk); #1;
        w_valid_i = 1'b0;
        exp_addr_q.delete();
        exp_b_q.delete();
        start_burst(32'h600, 8'd1, 3'd3, 2'b01, 4'd8, 6'h18, 1);
        beats(2, 1, 1'b0, cyc);
        finish_b(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi2mem_wr_burst_ctrl.md
Name: axi2mem_wr_burst_ctrl

Overview:
Write-burst controller sitting directly downstream of the AXI write-address buffer in the axi2mem bridge. Accepts one buffered AW burst at a time, pairs it with W-channel beats, and generates one memory write request per beat with a computed beat address (FIXED/INCR/WRAP). Issues the B response once the burst completes. Throughput is one beat per cycle when W-valid and memory grant are both high.

Parameters:
ADDR_WIDTH, 32, AW address and memory address width
DATA_WIDTH, 64, W data / memory data width (power of 2, >=8)
ID_WIDTH, 4, AXI ID width
USER_WIDTH, 6, AXI user width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
aw_valid_i  in  1  AW burst valid, from AW buffer
aw_addr_i  in  ADDR_WIDTH  burst start address
aw_len_i  in  8  beats-1
aw_size_i  in  3  log2 bytes per beat
aw_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
aw_id_i  in  ID_WIDTH  burst ID
aw_user_i  in  USER_WIDTH  burst user
aw_ready_o  out  1  AW accept
w_valid_i  in  1  write beat valid
w_data_i  in  DATA_WIDTH  write data
w_strb_i  in  DATA_WIDTH/8  byte strobes
w_last_i  in  1  last beat flag
w_ready_o  out  1  write beat accept
mem_req_o  out  1  memory write request
mem_addr_o  out  ADDR_WIDTH  beat byte address
mem_we_o  out  1  write enable, constant 1 while mem_req_o
mem_be_o  out  DATA_WIDTH/8  byte enables (= w_strb_i)
mem_wdata_o  out  DATA_WIDTH  write data (= w_data_i)
mem_gnt_i  in  1  memory grant
b_valid_o  out  1  write response valid
b_resp_o  out  2  00 OKAY, 10 SLVERR
b_id_o  out  ID_WIDTH  latched aw_id
b_user_o  out  USER_WIDTH  latched aw_user
b_ready_i  in  1  response accept

Behaviour:
- Reset (rst_i high at clock edge): state IDLE, beat counter 0, error flag 0; aw_ready_o=1 after reset, w_ready_o=0, mem_req_o=0, b_valid_o=0, b_resp_o=00, b_id_o/b_user_o=0. Reset mid-burst abandons the burst; no B issued.
- FSM IDLE: aw_ready_o=1. On aw_valid_i&aw_ready_o latch addr/len/size/burst/id/user, clear counter and error flag, -> BURST. First mem_req_o possible next cycle.
- BURST: mem_req_o=w_valid_i; w_ready_o=w_valid_i&mem_gnt_i; aw_ready_o=0. Beat transfers when w_valid_i&mem_gnt_i. mem_addr_o = current beat address.
- Per beat: counter++, address update: FIXED unchanged; INCR addr+(1<<size); WRAP mask=((len+1)<<size)-1, addr=(addr&~mask)|((addr+(1<<size))&mask). Arithmetic modulo 2^ADDR_WIDTH.
- Beat transferred with counter==len ends burst -> RESP, regardless of w_last_i.
- Error flag set (sticky for burst) if: w_last_i=1 on a beat with counter!=len; w_last_i=0 on final beat; aw_burst=11 (treated as INCR); aw_size > log2(DATA_WIDTH/8); WRAP with len not in {1,3,7,15} (treated as INCR). All beats still written.
- RESP: b_valid_o=1, b_resp_o=error?10:00, hold stable until b_ready_i; on handshake -> IDLE. aw_ready_o=0 and w_ready_o=0 in RESP.
- B valid cycle after the last beat's grant; next AW accepted earliest cycle after B handshake.
- mem_gnt_i low: w_ready_o low, address/counter held, mem_req_o/mem_addr_o stable while w_valid_i stays high.

Test Plan:
- INCR len=3 size=3 addr=0x100, gnt=1, W every cycle -> mem_addr 0x100,0x108,0x110,0x118 on 4 consecutive cycles; B OKAY with aw_id=5, user echoed.
- WRAP len=3 size=3 addr=0x118 -> mem_addr 0x118,0x100,0x108,0x110; B OKAY.
- FIXED len=2 size=2 addr=0x44, gnt toggling 1,0,1,0,1 -> 3 requests all at 0x44, w_ready only on granted cycles, B after 5 cycles.
- INCR len=3 with w_last on beat 2 -> all 4 beats written, B resp=10; size=4 on 64-bit bus also -> 10.
- b_ready low 4 cycles with next aw_valid pending -> b_valid/resp held, aw_ready 0 until handshake, then next burst starts.
- rst_i asserted after beat 1 of len=7 -> next cycle mem_req 0, b_valid 0, aw_ready 1; new burst starts at its own address.
